// File: rtl/lbist_pkg.sv
// Shared types and default sizing for the logic-BIST sequencing controller.
package lbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } lbist_state_e;

    localparam int unsigned DEF_N_PATTERNS = 16;
    localparam int unsigned DEF_ORA_LAT    = 1;
    localparam int unsigned DEF_CNT_W      = 8;

    // Value taken by fail_cnt / first_fail whenever a session's results are cleared.
    localparam int unsigned RES_RST = 0;

endpackage

// File: rtl/lbist_tag_pipe.sv
// Delay line of {valid, pattern index} tags matching the ORA result latency.
module lbist_tag_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_idx,
    output logic         o_valid,
    output logic [W-1:0] o_idx,
    output logic         o_pending
);

    logic [DEPTH-1:0] r_valid;
    logic [W-1:0]     r_idx [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_idx[i] <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_idx[i] <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_idx[0]   <= i_idx;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];

    // Tags still in flight behind the one currently being checked.
    generate
        if (DEPTH > 1) begin : g_pend
            assign o_pending = |r_valid[DEPTH-2:0];
        end else begin : g_nopend
            assign o_pending = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST session controller: seeds and steps the TPG, checks ORA results,
// and reports pass / failure count / first failing pattern.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int unsigned N_PATTERNS = DEF_N_PATTERNS,
    parameter int unsigned ORA_LAT    = DEF_ORA_LAT,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             ora_res,
    output logic             tpg_load,
    output logic             tpg_en,
    output logic             test_mode,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] RES_ZERO = CNT_W'(RES_RST);

    lbist_state_e     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_failed;

    logic             w_active;
    logic             w_abort;
    logic             w_flush;
    logic             w_issue;
    logic             w_tag_valid;
    logic [CNT_W-1:0] w_tag_idx;
    logic             w_pending;
    logic             w_mismatch;

    assign w_active   = (r_state == ST_SEED) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_abort    = abort && w_active;
    assign w_flush    = w_abort || (r_state == ST_SEED);
    assign w_issue    = (r_state == ST_RUN);
    assign w_mismatch = w_tag_valid && !ora_res;

    lbist_tag_pipe #(
        .DEPTH (ORA_LAT),
        .W     (CNT_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (w_flush),
        .i_valid   (w_issue),
        .i_idx     (r_cnt),
        .o_valid   (w_tag_valid),
        .o_idx     (w_tag_idx),
        .o_pending (w_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_failed   <= 1'b0;
            tpg_load   <= 1'b0;
            tpg_en     <= 1'b0;
            test_mode  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_cnt   <= RES_ZERO;
            first_fail <= RES_ZERO;
        end else begin
            tpg_load <= 1'b0;

            if (w_mismatch) begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                if (!r_failed) begin
                    first_fail <= w_tag_idx;
                    r_failed   <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_SEED;
                        tpg_load   <= 1'b1;
                        test_mode  <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        r_cnt      <= '0;
                        r_failed   <= 1'b0;
                        fail_cnt   <= RES_ZERO;
                        first_fail <= RES_ZERO;
                    end
                end
                ST_SEED: begin
                    r_state <= ST_RUN;
                    tpg_en  <= 1'b1;
                end
                ST_RUN: begin
                    if (r_cnt == LAST_IDX) begin
                        r_state <= ST_DRAIN;
                        tpg_en  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Final tag may be checked this cycle, so fold its result into pass.
                    if (!w_pending) begin
                        r_state   <= ST_DONE;
                        test_mode <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= !(r_failed || w_mismatch);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_abort) begin
                r_state    <= ST_IDLE;
                tpg_load   <= 1'b0;
                tpg_en     <= 1'b0;
                test_mode  <= 1'b0;
                busy       <= 1'b0;
                r_cnt      <= '0;
                r_failed   <= 1'b0;
                fail_cnt   <= RES_ZERO;
                first_fail <= RES_ZERO;
            end
        end
    end

endmodule

// File: tb/tb_lbist_ctrl.sv
// Directed self-checking bench for lbist_ctrl at ORA_LAT=1 and ORA_LAT=3.
module tb_lbist_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic ora_res = 1'b1;
    logic sel3 = 1'b0;

    logic a_load, a_en, a_tm, a_busy, a_done, a_pass;
    logic [7:0] a_fcnt, a_ffirst;
    logic b_load, b_en, b_tm, b_busy, b_done, b_pass;
    logic [7:0] b_fcnt, b_ffirst;

    logic o_load, o_en, o_tm, o_busy, o_done, o_pass;
    logic [7:0] o_fcnt, o_ffirst;
    logic [21:0] outs;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lbist_ctrl #(.N_PATTERNS(16), .ORA_LAT(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start && !sel3), .abort(abort && !sel3),
        .ora_res(ora_res), .tpg_load(a_load), .tpg_en(a_en), .test_mode(a_tm),
        .busy(a_busy), .done(a_done), .pass(a_pass), .fail_cnt(a_fcnt), .first_fail(a_ffirst)
    );

    lbist_ctrl #(.N_PATTERNS(16), .ORA_LAT(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start && sel3), .abort(abort && sel3),
        .ora_res(ora_res), .tpg_load(b_load), .tpg_en(b_en), .test_mode(b_tm),
        .busy(b_busy), .done(b_done), .pass(b_pass), .fail_cnt(b_fcnt), .first_fail(b_ffirst)
    );

    assign o_load   = sel3 ? b_load   : a_load;
    assign o_en     = sel3 ? b_en     : a_en;
    assign o_tm     = sel3 ? b_tm     : a_tm;
    assign o_busy   = sel3 ? b_busy   : a_busy;
    assign o_done   = sel3 ? b_done   : a_done;
    assign o_pass   = sel3 ? b_pass   : a_pass;
    assign o_fcnt   = sel3 ? b_fcnt   : a_fcnt;
    assign o_ffirst = sel3 ? b_ffirst : a_ffirst;
    assign outs = {o_load, o_en, o_tm, o_busy, o_done, o_pass, o_fcnt, o_ffirst};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one session; ora_res follows the mismatch mask on check cycles, idle_ora elsewhere.
    task automatic run_session(input int lat, input logic [15:0] mask, input logic idle_ora,
                               output int loads, output int ens, output int drains,
                               output int done_cyc);
        loads = 0; ens = 0; drains = 0; done_cyc = -1;
        sel3 = (lat == 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 64; cyc++) begin
            int idx;
            idx = cyc - 2 - lat;
            ora_res = (idx >= 0 && idx < 16) ? !mask[idx] : idle_ora;
            #1;
            loads += int'(o_load);
            ens   += int'(o_en);
            if (o_busy && !o_en && !o_load) drains++;
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
            tick();
        end
        ora_res = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        int en_pulses;
        sel3 = 1'b0;
        #3 rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if (outs !== 22'd0) $display("FAIL reset_outs: got %h want 0", outs);
        else n_pass++;
        rst_n = 1'b1;
        bad = 0; en_pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (outs !== 22'd0) bad++;
            en_pulses += int'(o_en);
        end
        n_checks++;
        if (bad != 0) $display("FAIL idle_outs: got %0d nonzero cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (en_pulses != 0) $display("FAIL idle_tpg_en: got %0d pulses want 0", en_pulses);
        else n_pass++;
    endtask

    task automatic test_clean();
        int loads, ens, drains, dc;
        run_session(1, 16'h0000, 1'b1, loads, ens, drains, dc);
        n_checks++;
        if (loads != 1) $display("FAIL clean_load: got %0d want 1", loads); else n_pass++;
        n_checks++;
        if (ens != 16) $display("FAIL clean_en: got %0d want 16", ens); else n_pass++;
        n_checks++;
        if (drains != 1) $display("FAIL clean_drain: got %0d want 1", drains); else n_pass++;
        n_checks++;
        if (dc != 19) $display("FAIL clean_done_cyc: got %0d want 19", dc); else n_pass++;
        n_checks++;
        if ({o_pass, o_fcnt, o_ffirst} !== {1'b1, 8'd0, 8'd0})
            $display("FAIL clean_result: got pass=%0d cnt=%0d first=%0d want 1/0/0", o_pass, o_fcnt, o_ffirst);
        else n_pass++;
    endtask

    task automatic test_mismatch();
        int loads, ens, drains, dc;
        run_session(1, 16'h8088, 1'b1, loads, ens, drains, dc);
        n_checks++;
        if (dc != 19) $display("FAIL mm_done_cyc: got %0d want 19", dc); else n_pass++;
        n_checks++;
        if (o_fcnt !== 8'd3) $display("FAIL mm_fail_cnt: got %0d want 3", o_fcnt); else n_pass++;
        n_checks++;
        if (o_ffirst !== 8'd3) $display("FAIL mm_first_fail: got %0d want 3", o_ffirst); else n_pass++;
        n_checks++;
        if (o_pass !== 1'b0) $display("FAIL mm_pass: got %0d want 0", o_pass); else n_pass++;
    endtask

    task automatic test_lat3();
        int loads, ens, drains, dc;
        run_session(3, 16'h0001, 1'b0, loads, ens, drains, dc);
        n_checks++;
        if (drains != 3) $display("FAIL lat3_drain: got %0d want 3", drains); else n_pass++;
        n_checks++;
        if (dc != 21) $display("FAIL lat3_done_cyc: got %0d want 21", dc); else n_pass++;
        n_checks++;
        if ({o_pass, o_fcnt, o_ffirst} !== {1'b0, 8'd1, 8'd0})
            $display("FAIL lat3_result: got pass=%0d cnt=%0d first=%0d want 0/1/0", o_pass, o_fcnt, o_ffirst);
        else n_pass++;
        sel3 = 1'b0;
    endtask

    task automatic test_abort();
        int loads, ens, drains, dc;
        sel3 = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) begin
            ora_res = (c >= 3) ? 1'b0 : 1'b1;
            tick();
        end
        n_checks++;
        if (o_en !== 1'b1) $display("FAIL abort_in_run: got tpg_en=%0d want 1", o_en); else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (outs !== 22'd0) $display("FAIL abort_outs: got %h want 0", outs); else n_pass++;
        ora_res = 1'b0;
        tick(); tick();
        n_checks++;
        if (outs !== 22'd0) $display("FAIL abort_late_check: got %h want 0", outs); else n_pass++;
        ora_res = 1'b1;
        run_session(1, 16'h0000, 1'b1, loads, ens, drains, dc);
        n_checks++;
        if (dc != 19 || ens != 16) $display("FAIL abort_rerun_timing: got done=%0d en=%0d want 19/16", dc, ens);
        else n_pass++;
        n_checks++;
        if ({o_pass, o_fcnt, o_ffirst} !== {1'b1, 8'd0, 8'd0})
            $display("FAIL abort_rerun_result: got pass=%0d cnt=%0d first=%0d want 1/0/0", o_pass, o_fcnt, o_ffirst);
        else n_pass++;
    endtask

    task automatic test_reset_drain();
        int loads, ens, drains, dc;
        logic found;
        sel3 = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ora_res = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (o_busy && !o_en && !o_load) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found) $display("FAIL rd_reach_drain: got no DRAIN want DRAIN");
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (outs !== 22'd0) $display("FAIL rd_async_clear: got %h want 0", outs); else n_pass++;
        ora_res = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        run_session(1, 16'h8088, 1'b1, loads, ens, drains, dc);
        n_checks++;
        if (o_fcnt !== 8'd3) $display("FAIL rd_pre_fail_cnt: got %0d want 3", o_fcnt); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (outs !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0})
            $display("FAIL rd_seed_clear: got %h want %h", outs, {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
        else n_pass++;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (o_done) found = 1'b1;
        end
        n_checks++;
        if (!found || {o_pass, o_fcnt, o_ffirst} !== {1'b1, 8'd0, 8'd0})
            $display("FAIL rd_fresh_session: got done=%0d pass=%0d cnt=%0d want 1/1/0", o_done, o_pass, o_fcnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_mismatch();
        test_lat3();
        test_abort();
        test_reset_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lbist_ctrl.md
# lbist_ctrl

Sequencing controller for the logic-BIST datapath: loads the test-pattern generator seed, steps the generator for a fixed number of patterns while the CUT runs in test mode, and checks each registered per-pattern result from the output result analyzer. It is the single block that turns the free-running TPG/CUT/ORA chain into a start/done test session with a pass flag, a failure count and the first failing pattern index. It sits beside the ORA and drives the TPG enable/load and the CUT input mux select.

## Interface
- `N_PATTERNS`, 16: patterns applied per session; legal range ≥ 1.
- `ORA_LAT`, 1: cycles from pattern applied at the CUT input to the matching `ora_res` being valid; legal range ≥ 1.
- `CNT_W`, 8: width of the pattern index and the failure counter; must satisfy 2^CNT_W ≥ N_PATTERNS.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `start`  in  1  level; sampled in IDLE or DONE to begin a session.
- `abort`  in  1  level; cancels an active session.
- `ora_res`  in  1  registered ORA compare result; 1 = match.
- `tpg_load`  out  1  one-cycle seed-load strobe to the TPG.
- `tpg_en`  out  1  advance the TPG by one pattern at this edge.
- `test_mode`  out  1  CUT input mux select; 1 = TPG drives the CUT.
- `busy`  out  1  session in progress.
- `done`  out  1  session complete; results are valid.
- `pass`  out  1  1 when `done` and no mismatch was recorded.
- `fail_cnt`  out  CNT_W  number of mismatching patterns, saturating.
- `first_fail`  out  CNT_W  index of the first mismatching pattern; 0 when there is none.

## Operation
- FSM states: IDLE, SEED, RUN, DRAIN, DONE.
- IDLE: all outputs 0. `start`=1 moves to SEED.
- SEED: `tpg_load`=1, `test_mode`=1, `busy`=1. The pattern counter, `fail_cnt`, `first_fail` and the fail flag are cleared. Always moves to RUN on the next cycle.
- RUN: `tpg_en`=1, `test_mode`=1, `busy`=1. RUN cycle k applies pattern index k. The counter advances from 0 to N_PATTERNS-1. At the cycle where index N_PATTERNS-1 is applied, the FSM moves to DRAIN.
- DRAIN: `tpg_en`=0, `test_mode`=1, `busy`=1. The FSM stays in DRAIN until the check pipeline is empty, then moves to DONE.
- DONE: `done`=1, `busy`=0, `test_mode`=0. `pass` = (fail_cnt == 0). Results hold. `start`=1 moves to SEED and clears the results there.
- Check pipeline: a valid bit plus a CNT_W index tag per pattern, delayed ORA_LAT cycles. A tag is issued in every RUN cycle.
- When a tag emerges with valid=1 and `ora_res`=0:
  - `fail_cnt` increments, saturating at 2^CNT_W-1.
  - If this is the first mismatch of the session, the tag index is latched into `first_fail` and the fail flag is set.
- `ora_res` is ignored whenever no valid tag is emerging.
- `abort`=1 in SEED, RUN or DRAIN moves to IDLE at the next edge. The pipeline and all results are cleared. `abort` has no effect in IDLE or DONE.
- If `abort` and `start` are both high in IDLE, `abort` has no effect and `start` is taken.

## Timing
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs are 0. Pipeline valid bits are 0.
- `start` sampled high at edge t (FSM in IDLE): SEED during cycle t+1, RUN from t+2.
- Pattern k is at the CUT in cycle t+2+k. Its `ora_res` is checked in cycle t+2+k+ORA_LAT.
- DRAIN lasts ORA_LAT cycles.
- `done` first rises in cycle t+2+N_PATTERNS+ORA_LAT. Session length is N_PATTERNS+ORA_LAT+2 cycles from the `start` edge.
- N_PATTERNS=1: RUN lasts exactly one cycle.
- A mismatch on the final pattern is still counted before `done` rises.

## Structure
- Package `lbist_pkg`: FSM state enum, default N_PATTERNS/ORA_LAT/CNT_W constants, and a reset-value constant for the results.
- Sub-module `lbist_tag_pipe`: the ORA_LAT-deep shift register of {valid, index}, with synchronous flush and asynchronous active-low reset.
- The FSM, the counters and the result registers live in `lbist_ctrl`.

## Test plan
- Reset then idle: all outputs are 0. Hold `start`=0 for 10 cycles: outputs stay 0 and `tpg_en` never pulses.
- Clean run, N_PATTERNS=16, ORA_LAT=1, `ora_res`=1 throughout:
  - `tpg_load` pulses once.
  - `tpg_en` is high for exactly 16 cycles.
  - `done` rises 19 cycles after the `start` edge, with `pass`=1, `fail_cnt`=0, `first_fail`=0.
- Mismatches on patterns 3, 7 and 15 (the last): `fail_cnt`=3, `first_fail`=3, `pass`=0.
- ORA_LAT=3 with a mismatch on pattern 0 only:
  - DRAIN lasts 3 cycles.
  - `first_fail`=0 with `pass`=0 and `fail_cnt`=1.
  - Drive `ora_res`=0 outside valid check cycles: this must not change the count.
- Abort at RUN pattern 5: next cycle the FSM is in IDLE, outputs are 0, and no late `ora_res` check is counted. A following `start` runs a full clean session.
- Reset edge case: deassert `rst_n` mid-DRAIN; all outputs clear asynchronously. Re-run from DONE with `start`: results clear in SEED and a fresh session completes correctly.
